// File: rtl/ht_task_arb_pkg.sv
// hash_table: command encoding and sizing helpers shared by the task arbiter files.
package hash_table;
    localparam int HT_CMD_WIDTH = 2;
    typedef enum logic [HT_CMD_WIDTH-1:0] {
        HT_NOP    = 2'd0,
        HT_SEARCH = 2'd1,
        HT_INSERT = 2'd2,
        HT_DELETE = 2'd3
    } ht_command_t;
    function automatic int ht_id_width(input int n_ports);
        return (n_ports > 2) ? $clog2(n_ports) : 1;
    endfunction
endpackage

// File: rtl/ht_pend_fifo.sv
// ht_pend_fifo: in-order FIFO of granted port ids awaiting their table results.
module ht_pend_fifo
    import hash_table::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q + AW'(push_i);
        rd_d  = rd_q + AW'(pop_i);
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // Id storage needs no reset; only occupied slots are ever read.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/ht_task_arb.sv
// ht_task_arb: round-robin task merge into the hash table with in-order result steering (HT_TASK_ARB_STATS_EN adds per-port counters).
module ht_task_arb
    import hash_table::*;
#(
    parameter int N_PORTS     = 2,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int CMD_WIDTH   = HT_CMD_WIDTH,
    parameter int RES_WIDTH   = 64,
    parameter int PEND_DEPTH  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_PORTS-1:0]             cl_valid_i,
    output logic [N_PORTS-1:0]             cl_ready_o,
    input  logic [N_PORTS*KEY_WIDTH-1:0]   cl_key_i,
    input  logic [N_PORTS*VALUE_WIDTH-1:0] cl_value_i,
    input  logic [N_PORTS*CMD_WIDTH-1:0]   cl_cmd_i,
    output logic                           task_valid_o,
    input  logic                           task_ready_i,
    output logic [KEY_WIDTH-1:0]           task_key_o,
    output logic [VALUE_WIDTH-1:0]         task_value_o,
    output logic [CMD_WIDTH-1:0]           task_cmd_o,
    input  logic                           res_valid_i,
    output logic                           res_ready_o,
    input  logic [RES_WIDTH-1:0]           res_data_i,
    output logic [N_PORTS-1:0]             cl_res_valid_o,
    input  logic [N_PORTS-1:0]             cl_res_ready_i,
    output logic [RES_WIDTH-1:0]           cl_res_data_o,
`ifdef HT_TASK_ARB_STATS_EN
    output logic [N_PORTS*32-1:0]          grant_cnt_o,
    output logic [N_PORTS*32-1:0]          res_cnt_o,
`endif
    output logic                           err_o
);
    localparam int IDW = ht_id_width(N_PORTS);
    logic                   found, load, grant, full, empty, pop;
    logic [IDW-1:0]         gnt_id, head, rr_q, rr_d;
    logic                   task_valid_q, task_valid_d, err_q, err_d;
    logic [KEY_WIDTH-1:0]   task_key_q, task_key_d;
    logic [VALUE_WIDTH-1:0] task_value_q, task_value_d;
    logic [CMD_WIDTH-1:0]   task_cmd_q, task_cmd_d;
    // Round-robin search: first valid port at or after rr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!found && cl_valid_i[(int'(rr_q) + i) % N_PORTS]) begin
                found  = 1'b1;
                gnt_id = IDW'((int'(rr_q) + i) % N_PORTS);
            end
        end
    end
    // Grant and output-stage next state; full is registered, so a same-cycle pop frees nothing yet.
    always_comb begin
        load         = !task_valid_q || task_ready_i;
        grant        = load && !full && found;
        cl_ready_o   = grant ? (N_PORTS'(1) << gnt_id) : '0;
        rr_d         = grant ? ((int'(gnt_id) == N_PORTS - 1) ? '0 : gnt_id + 1'b1) : rr_q;
        task_valid_d = load ? grant : task_valid_q;
        task_key_d   = grant ? cl_key_i[int'(gnt_id)*KEY_WIDTH +: KEY_WIDTH] : task_key_q;
        task_value_d = grant ? cl_value_i[int'(gnt_id)*VALUE_WIDTH +: VALUE_WIDTH] : task_value_q;
        task_cmd_d   = grant ? cl_cmd_i[int'(gnt_id)*CMD_WIDTH +: CMD_WIDTH] : task_cmd_q;
    end
    // Result steering to the oldest outstanding owner; orphan results are dropped and flagged.
    always_comb begin
        cl_res_valid_o = (res_valid_i && !empty) ? (N_PORTS'(1) << head) : '0;
        res_ready_o    = empty || cl_res_ready_i[head];
        pop            = res_valid_i && !empty && cl_res_ready_i[head];
        err_d          = err_q || (res_valid_i && empty);
    end
    // Output register, round-robin pointer and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q         <= '0;
            task_valid_q <= 1'b0;
            task_key_q   <= '0;
            task_value_q <= '0;
            task_cmd_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            task_valid_q <= task_valid_d;
            task_key_q   <= task_key_d;
            task_value_q <= task_value_d;
            task_cmd_q   <= task_cmd_d;
            err_q        <= err_d;
        end
    end
    ht_pend_fifo #(.DEPTH(PEND_DEPTH), .W(IDW)) u_pend (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .pop_i   (pop),
        .din_i   (gnt_id),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign task_valid_o  = task_valid_q;
    assign task_key_o    = task_key_q;
    assign task_value_o  = task_value_q;
    assign task_cmd_o    = task_cmd_q;
    assign cl_res_data_o = res_data_i;
    assign err_o         = err_q;
`ifdef HT_TASK_ARB_STATS_EN
    logic [N_PORTS-1:0][31:0] grant_cnt_q, grant_cnt_d, res_cnt_q, res_cnt_d;
    // Per-port accepted-task and delivered-result counters, wrapping at 2^32.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            grant_cnt_d[p] = grant_cnt_q[p] + 32'(cl_ready_o[p]);
            res_cnt_d[p]   = res_cnt_q[p] + 32'(cl_res_valid_o[p] && res_ready_o);
        end
    end
    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant_cnt_q <= '0;
            res_cnt_q   <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            res_cnt_q   <= res_cnt_d;
        end
    end
    assign grant_cnt_o = grant_cnt_q;
    assign res_cnt_o   = res_cnt_q;
`endif
endmodule

// File: tb/tb_ht_task_arb.sv
// tb_ht_task_arb: directed self-checking bench for ht_task_arb with PEND_DEPTH=4.
module tb_ht_task_arb;
    import hash_table::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cl_valid = '0, cl_ready, cl_res_valid, cl_res_ready = '0;
    logic [31:0] key0 = '0, key1 = '0;
    logic [15:0] val0 = 16'h0a0a, val1 = 16'h1b1b;
    logic [1:0]  cmd0 = HT_SEARCH, cmd1 = HT_INSERT;
    logic        task_valid, task_ready = 1'b0, res_valid = 1'b0, res_ready, err;
    logic [31:0] task_key;
    logic [15:0] task_value;
    logic [1:0]  task_cmd;
    logic [63:0] res_data = 64'hdead_beef_0123_4567, cl_res_data;
    int          checks = 0, failures = 0;
    ht_task_arb #(.N_PORTS(2), .KEY_WIDTH(32), .VALUE_WIDTH(16), .CMD_WIDTH(2),
                  .RES_WIDTH(64), .PEND_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .cl_valid_i     (cl_valid),
        .cl_ready_o     (cl_ready),
        .cl_key_i       ({key1, key0}),
        .cl_value_i     ({val1, val0}),
        .cl_cmd_i       ({cmd1, cmd0}),
        .task_valid_o   (task_valid),
        .task_ready_i   (task_ready),
        .task_key_o     (task_key),
        .task_value_o   (task_value),
        .task_cmd_o     (task_cmd),
        .res_valid_i    (res_valid),
        .res_ready_o    (res_ready),
        .res_data_i     (res_data),
        .cl_res_valid_o (cl_res_valid),
        .cl_res_ready_i (cl_res_ready),
        .cl_res_data_o  (cl_res_data),
        .err_o          (err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask
    initial begin
        key0 = 32'ha0;
        key1 = 32'h11;
        #3;
        chk("rst_task_valid", 64'(task_valid), 64'd0);
        chk("rst_task_key", 64'(task_key), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cl_ready", 64'(cl_ready), 64'd0);
        cyc(); rst_n = 1'b1;
        // single requester on port 1
        cyc(); cl_valid = 2'b10; task_ready = 1'b1; #1;
        chk("t1_grant_p1", 64'(cl_ready), 64'h2);
        cyc(); cl_valid = 2'b00; #1;
        chk("t1_task_valid", 64'(task_valid), 64'd1);
        chk("t1_task_key", 64'(task_key), 64'h11);
        chk("t1_task_value", 64'(task_value), 64'h1b1b);
        chk("t1_task_cmd", 64'(task_cmd), 64'(HT_INSERT));
        cyc(); res_valid = 1'b1; cl_res_ready = 2'b11; #1;
        chk("t1_res_steer", 64'(cl_res_valid), 64'h2);
        chk("t1_res_ready", 64'(res_ready), 64'd1);
        chk("t1_res_data", cl_res_data, 64'hdead_beef_0123_4567);
        cyc(); res_valid = 1'b0; #1;
        chk("t1_idle_valid", 64'(task_valid), 64'd0);
        // alternation with both ports requesting
        cl_valid = 2'b11; #1;
        chk("t2_grant0", 64'(cl_ready), 64'h1);
        cyc(); #1;
        chk("t2_grant1", 64'(cl_ready), 64'h2);
        chk("t2_key0", 64'(task_key), 64'ha0);
        cyc(); #1;
        chk("t2_grant2", 64'(cl_ready), 64'h1);
        chk("t2_key1", 64'(task_key), 64'h11);
        cyc(); cl_valid = 2'b00; res_valid = 1'b1; #1;
        chk("t2_key2", 64'(task_key), 64'ha0);
        chk("t2_res0", 64'(cl_res_valid), 64'h1);
        cyc(); #1;
        chk("t2_res1", 64'(cl_res_valid), 64'h2);
        cyc(); #1;
        chk("t2_res2", 64'(cl_res_valid), 64'h1);
        // backpressure from the table (rr now points at port 1, only port 0 asks)
        cyc(); res_valid = 1'b0; key0 = 32'hb0; cl_valid = 2'b01; #1;
        chk("t3_grant_p0", 64'(cl_ready), 64'h1);
        cyc(); task_ready = 1'b0; key0 = 32'hc0; cl_valid = 2'b11; #1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_valid", 64'(task_valid), 64'd1);
            chk("t3_stall_key", 64'(task_key), 64'hb0);
            chk("t3_stall_ready", 64'(cl_ready), 64'd0);
            cyc(); #1;
        end
        task_ready = 1'b1; #1;
        chk("t3_release_grant_p1", 64'(cl_ready), 64'h2);
        cyc(); cl_valid = 2'b00; res_valid = 1'b1; #1;
        chk("t3_next_key", 64'(task_key), 64'h11);
        chk("t3_res0", 64'(cl_res_valid), 64'h1);
        cyc(); #1;
        chk("t3_res1", 64'(cl_res_valid), 64'h2);
        // pending FIFO full at depth 4 (rr back at port 0)
        cyc(); res_valid = 1'b0; cl_valid = 2'b11; #1;
        chk("t4_g1", 64'(cl_ready), 64'h1);
        cyc(); #1; chk("t4_g2", 64'(cl_ready), 64'h2);
        cyc(); #1; chk("t4_g3", 64'(cl_ready), 64'h1);
        cyc(); #1; chk("t4_g4", 64'(cl_ready), 64'h2);
        cyc(); #1; chk("t4_full_a", 64'(cl_ready), 64'h0);
        cyc(); res_valid = 1'b1; #1;
        chk("t4_full_pop_steer", 64'(cl_res_valid), 64'h1);
        chk("t4_full_same_cycle", 64'(cl_ready), 64'h0);
        cyc(); res_valid = 1'b0; #1;
        chk("t4_g5_after_pop", 64'(cl_ready), 64'h1);
        // head stall: FIFO now holds ids 1,0,1,0
        cyc(); cl_valid = 2'b00; res_valid = 1'b1; cl_res_ready = 2'b01; #1;
        chk("t5_stall_valid", 64'(cl_res_valid), 64'h2);
        chk("t5_stall_ready", 64'(res_ready), 64'd0);
        cyc(); #1;
        chk("t5_still_head", 64'(cl_res_valid), 64'h2);
        cl_res_ready = 2'b11; #1;
        chk("t5_release_ready", 64'(res_ready), 64'd1);
        cyc(); #1; chk("t5_r1", 64'(cl_res_valid), 64'h1);
        cyc(); #1; chk("t5_r2", 64'(cl_res_valid), 64'h2);
        cyc(); #1; chk("t5_r3", 64'(cl_res_valid), 64'h1);
        // orphan result with the FIFO empty
        cyc(); #1;
        chk("t6_orphan_ready", 64'(res_ready), 64'd1);
        chk("t6_orphan_valid", 64'(cl_res_valid), 64'h0);
        chk("t6_err_not_yet", 64'(err), 64'd0);
        cyc(); res_valid = 1'b0; #1;
        chk("t6_err_set", 64'(err), 64'd1);
        cyc(); #1;
        chk("t6_err_sticky", 64'(err), 64'd1);
        // async reset in the middle of a burst
        cl_valid = 2'b11;
        cyc(); cyc(); #1;
        chk("t6_burst_valid", 64'(task_valid), 64'd1);
        cl_valid = 2'b00; rst_n = 1'b0; #1;
        chk("t6_rst_task_valid", 64'(task_valid), 64'd0);
        chk("t6_rst_task_key", 64'(task_key), 64'd0);
        chk("t6_rst_err", 64'(err), 64'd0);
        chk("t6_rst_res_ready", 64'(res_ready), 64'd1);
        cyc(); rst_n = 1'b1; res_valid = 1'b1; #1;
        chk("t6_fifo_cleared", 64'(cl_res_valid), 64'h0);
        cyc(); res_valid = 1'b0; #1;
        chk("t6_stale_result_err", 64'(err), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
